// File: rtl/core_test_pkg.sv
// core_test_pkg
// Shared definitions for the on-chip core test controller.
//   ctrl_state_e      : controller FSM states
//   FAIL_CH_NONE_BIT  : fill bit for the fail_ch "no failing channel" code
//                       (the whole field is filled with this bit, i.e. all-ones)
//   count_width()     : bits needed to hold the values 0..max_value
package core_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } ctrl_state_e;

    localparam logic FAIL_CH_NONE_BIT = 1'b1;

    // Never returns less than one bit, so degenerate counters stay legal.
    function automatic int count_width(input int max_value);
        if (max_value < 1) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/core_test_ctrl_ch_checker.sv
// ch_checker
// Watches one result channel of the core during a test run.
// Ports:
//   clk, reset   : clock and asynchronous active-low reset
//   clear        : drop the passed flag (a new run is starting)
//   run          : controller is in RUN; values are only judged then
//   valid, value : result strobe and value from the core
//   expected     : value this channel must produce
//   passed       : sticky flag, set once a matching value has been seen
//   passed_next  : what passed will be after the coming edge
//   mismatch     : STRICT only; first valid value was wrong (combinational)
module ch_checker #(
    parameter int WIDTH  = 32,
    parameter bit STRICT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic             valid,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] expected,
    output logic             passed,
    output logic             passed_next,
    output logic             mismatch
);

    logic passed_q;
    logic passed_d;
    logic hit;

    // A wrong first value can only be seen while the channel has not passed;
    // once passed, later values on the channel no longer matter. A wrong
    // value ends the run, so passed_q alone tells us whether a first value
    // has already been accepted.
    always_comb begin
        hit      = run && valid && (value == expected);
        passed_d = passed_q;
        mismatch = 1'b0;
        if (clear) begin
            passed_d = 1'b0;
        end else if (hit) begin
            passed_d = 1'b1;
        end
        if (STRICT && run && valid && !passed_q && (value != expected)) begin
            mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            passed_q <= 1'b0;
        end else begin
            passed_q <= passed_d;
        end
    end

    assign passed      = passed_q;
    assign passed_next = passed_d;

endmodule

// File: rtl/core_test_ctrl.sv
// core_test_ctrl
// On-chip test controller for the pipelined core: holds the core in reset,
// lets it run for a bounded number of cycles and checks its result channels.
// Ports:
//   clk, reset          : clock and asynchronous active-low reset
//   start               : one-cycle run request (IDLE, PASS, FAIL only)
//   ch_valid/ch_value   : per-channel result strobe and packed values
//   exp_value           : packed expected values, stable during a run
//   core_reset          : active-high reset to the core
//   busy / pass / fail  : run in progress / run passed / run failed
//   pass_mask           : per-channel passed flags
//   fail_ch             : lowest mismatching channel, all-ones if none/timeout
//   cycle_count         : RUN cycles elapsed in the current/last run
module core_test_ctrl
    import core_test_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_CH      = 1,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 30,
    parameter bit STRICT      = 1'b0,
    parameter bit AUTO_START  = 1'b1,
    localparam int FAIL_CH_W  = $clog2(NUM_CH) + 1,
    localparam int CNT_W      = count_width(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH*WIDTH-1:0] ch_value,
    input  logic [NUM_CH*WIDTH-1:0] exp_value,
    output logic                    core_reset,
    output logic                    busy,
    output logic                    pass,
    output logic                    fail,
    output logic [NUM_CH-1:0]       pass_mask,
    output logic [FAIL_CH_W-1:0]    fail_ch,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam int HOLD_W = count_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]    HOLD_LOAD    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [FAIL_CH_W-1:0] FAIL_CH_NONE = {FAIL_CH_W{FAIL_CH_NONE_BIT}};

    ctrl_state_e          state_q, state_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [FAIL_CH_W-1:0] fail_ch_q, fail_ch_d;

    logic                 in_run;
    logic                 enter_hold;
    logic [NUM_CH-1:0]    passed_vec;
    logic [NUM_CH-1:0]    passed_next_vec;
    logic [NUM_CH-1:0]    mismatch_vec;
    logic [FAIL_CH_W-1:0] first_bad;

    assign in_run = (state_q == ST_RUN);

    // Kept apart from the FSM process: the checkers' clear depends on it and
    // the FSM depends on the checkers, so one shared process would look like
    // a combinational loop even though none exists.
    always_comb begin
        enter_hold = 1'b0;
        case (state_q)
            ST_IDLE:          enter_hold = AUTO_START ? 1'b1 : start;
            ST_PASS, ST_FAIL: enter_hold = start;
            default:          enter_hold = 1'b0;
        endcase
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_checker #(
            .WIDTH  (WIDTH),
            .STRICT (STRICT)
        ) u_chk (
            .clk         (clk),
            .reset       (reset),
            .clear       (enter_hold),
            .run         (in_run),
            .valid       (ch_valid[i]),
            .value       (ch_value[i*WIDTH +: WIDTH]),
            .expected    (exp_value[i*WIDTH +: WIDTH]),
            .passed      (passed_vec[i]),
            .passed_next (passed_next_vec[i]),
            .mismatch    (mismatch_vec[i])
        );
    end

    // Scanning downwards leaves the lowest mismatching index as the winner.
    always_comb begin
        first_bad = FAIL_CH_NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mismatch_vec[i]) begin
                first_bad = FAIL_CH_W'(i);
            end
        end
    end

    // The hold counter is loaded with HOLD_CYCLES-1 so the edge that sees it
    // at zero is the HOLD_CYCLES-th edge after entry and moves to RUN.
    // In RUN a mismatch beats completion, and completion beats the timeout,
    // so a channel finishing on the last allowed edge still passes.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_ch_d   = fail_ch_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (enter_hold) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = HOLD_LOAD;
                    cycle_cnt_d = '0;
                    fail_ch_d   = FAIL_CH_NONE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (|mismatch_vec) begin
                    state_d   = ST_FAIL;
                    fail_ch_d = first_bad;
                end else if (&passed_next_vec) begin
                    state_d = ST_PASS;
                end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            fail_ch_q   <= FAIL_CH_NONE;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_ch_q   <= fail_ch_d;
        end
    end

    // Decoded straight from the state flop, so the core's reset rises the
    // moment the controller's own reset is asserted.
    assign core_reset  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign busy        = (state_q == ST_HOLD) || (state_q == ST_RUN);
    assign pass        = (state_q == ST_PASS);
    assign fail        = (state_q == ST_FAIL);
    assign pass_mask   = passed_vec;
    assign fail_ch     = fail_ch_q;
    assign cycle_count = cycle_cnt_q;

endmodule
